alu4_sched: RTL
===============

# alu4_sched

- Two-requester scheduler and sequencer for the 4-bit logic/arithmetic units (AND, OR, XOR, ADD); each unit has its own enable-gated operand inputs.
- Arbitrates round-robin between two clients, issues one operation at a time to the selected unit's enable, and registers the result.
- Returns the result to the winner with a one-cycle ack.
- Sits between the register/control layer and the combinational ALU units.

## Interface
- W, 4, operand/result width
- CNT_W, 8, width of completed-operation counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  operation request, one per client; held until ack
- op0, op1  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD
- a0, b0, a1, b1  in  W  operands, stable while req high
- ack0, ack1  out  1  one-cycle completion pulse to the granted client
- res  out  W  registered result, valid while ackN high, held until next DONE
- res_c  out  1  ADD carry-out, 0 for logic ops
- gnt  out  2  one-hot current owner, 00 when idle
- busy  out  1  high in ISSUE and DONE
- alu_en  out  4  one-hot unit enable: bit0 AND, bit1 OR, bit2 XOR, bit3 ADD
- alu_a, alu_b  out  W  operands to the units, 0 when no enable asserted
- alu_y  in  W  result from the enabled unit (combinational, muxed externally)
- alu_c  in  1  carry from ADD unit
- op_cnt  out  CNT_W  count of completed operations, wraps

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: sample req0/req1 at each edge.
  - On any request, pick the winner, capture its op/a/b into internal registers, set gnt, and go to ISSUE.
- Arbitration: a priority pointer prefers client 0 after reset.
  - With a single request, that client wins regardless of the pointer.
  - With both requesting, the pointer's client wins.
  - After each grant, the pointer moves to the other client. Strict alternation under contention.
- ISSUE: assert alu_en bit for the captured op; drive alu_a/alu_b from the captured operands.
  - At the end of the cycle, register res<=alu_y and res_c<=(op==ADD)?alu_c:0.
  - Go to DONE.
- DONE: pulse the granted client's ack. op_cnt increments by 1 (wraps from 2^CNT_W-1 to 0). Clear gnt and go to IDLE.
- Client protocol:
  - Deassert req on the edge where ack is sampled high; that client is not sampled again until the following IDLE edge.
  - A req still high at the next IDLE edge is a new request.
- Dropping req during ISSUE/DONE does not abort: the operation completes and ack still pulses.
- Operand changes after capture are ignored.
- alu_en is all-zero outside ISSUE. alu_a/alu_b are 0 outside ISSUE, so operands are never presented to a disabled unit.
- Reset (any time, including mid-operation):
  - State to IDLE; pointer to client 0.
  - Outputs go to reset values: ack0/ack1=0, res=0, res_c=0, gnt=00, busy=0, alu_en=0000, alu_a=0, alu_b=0, op_cnt=0.
  - The in-flight operation is discarded with no ack.

## Timing
- All outputs are registered, except that alu_a/alu_b/alu_en are decoded from state plus captured registers.
  - alu_a/alu_b/alu_en carry no combinational path from req/op/a/b inputs.
- Latency with req sampled high at edge k:
  - ISSUE during cycle k..k+1, result sampled at edge k+1.
  - ack, res and res_c valid during cycle k+1..k+2.
  - IDLE from edge k+2; next sample at edge k+3.
- Maximum throughput: one operation per 3 cycles.
- Under continuous contention, acks alternate 0,1,0,1 with 3-cycle spacing.
- The ALU units see exactly one cycle of stable enable and operands per operation.
  - The alu_y path must settle within one clock period.

## Test plan
- Reset, then req0 only, op=00, a0=4'b1100, b0=4'b1010:
  - alu_en=0001 for one cycle.
  - ack0 pulses 2 cycles after the sample edge, with res=4'b1000, res_c=0.
  - op_cnt=1.
- req1 only, op=11, a1=4'hF, b1=4'h1 → alu_en=1000; res=4'h0, res_c=1, ack1 one cycle.
- req0 and req1 held high continuously after reset:
  - Grants go 0,1,0,1 and acks alternate every 3 cycles.
  - Each res matches the respective op (e.g. XOR 4'h5^4'h3 = 4'h6).
- req0 asserted, then a0 changed and req0 dropped during ISSUE → result uses the captured operands; ack0 still pulses.
- rst_n pulsed low during ISSUE:
  - All outputs go to 0 immediately (asynchronous) and no ack follows.
  - After release, a pending req1 with req0 also high is granted to client 0 (pointer reset).
- Issue 256 operations (CNT_W=8) → op_cnt wraps to 0 on the 256th ack.

Source files
------------

// File: rtl/alu4_sched.sv
// alu4_sched: two-client round-robin scheduler and sequencer for the
// external 4-bit AND/OR/XOR/ADD units. It grants one operation at a time,
// drives the selected unit for one cycle, registers the result and returns
// it to the winning client with a single-cycle ack.
module alu4_sched #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             ack0,
    output logic             ack1,
    output logic [W-1:0]     res,
    output logic             res_c,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [3:0]       alu_en,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_c,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             ptr, ptr_nxt;      // 0: client 0 preferred on contention
    logic [1:0]       op_q, op_nxt;
    logic [W-1:0]     a_q, a_nxt;
    logic [W-1:0]     b_q, b_nxt;
    logic [1:0]       gnt_nxt;
    logic             ack0_nxt, ack1_nxt;
    logic [W-1:0]     res_nxt;
    logic             res_c_nxt;
    logic             busy_nxt;
    logic [CNT_W-1:0] op_cnt_nxt;
    logic             win1;

    // State, captured operation and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ptr    <= 1'b0;
            op_q   <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
            gnt    <= 2'b00;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            res    <= '0;
            res_c  <= 1'b0;
            busy   <= 1'b0;
            op_cnt <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            op_q   <= op_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            gnt    <= gnt_nxt;
            ack0   <= ack0_nxt;
            ack1   <= ack1_nxt;
            res    <= res_nxt;
            res_c  <= res_c_nxt;
            busy   <= busy_nxt;
            op_cnt <= op_cnt_nxt;
        end
    end

    // Next-state, arbitration, capture and result/ack sequencing
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        op_nxt     = op_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        gnt_nxt    = gnt;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        res_nxt    = res;
        res_c_nxt  = res_c;
        busy_nxt   = busy;
        op_cnt_nxt = op_cnt;
        win1       = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    // A lone requester always wins; on contention the pointer decides
                    win1      = req1 && (!req0 || ptr);
                    op_nxt    = win1 ? op1 : op0;
                    a_nxt     = win1 ? a1 : a0;
                    b_nxt     = win1 ? b1 : b0;
                    gnt_nxt   = win1 ? 2'b10 : 2'b01;
                    ptr_nxt   = !win1;
                    busy_nxt  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                res_nxt    = alu_y;
                res_c_nxt  = (op_q == OP_ADD) ? alu_c : 1'b0;
                ack0_nxt   = gnt[0];
                ack1_nxt   = gnt[1];
                op_cnt_nxt = CNT_W'(op_cnt + 1'b1);
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Unit enable and operands: decoded only from state and captured registers
    always_comb begin
        alu_en = 4'b0000;
        alu_a  = '0;
        alu_b  = '0;
        if (state == S_ISSUE) begin
            alu_en = 4'(4'b0001 << op_q);
            alu_a  = a_q;
            alu_b  = b_q;
        end
    end

endmodule
